phase_timer: RTL

Parametrised interval timer for the traffic-light FSM. It is the next generation of the fixed 3 s counter. It counts a programmable number of divided-clock ticks per start request, supports one-shot and auto-reload modes, hold/abort, and reports remaining count and a single-cycle expiry pulse. It sits between the clock divider (tick source) and the light-sequencing FSM, which loads a different duration per light phase.

---
 rtl/phase_timer.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/phase_timer.sv
// phase_timer: programmable interval timer for the traffic-light sequencer.
// Counts qualified ticks (tick_en) down from a loaded duration. It supports
// one-shot and auto-reload modes, hold/abort control, and a one-cycle expiry
// pulse. All outputs are registered.
// Optional build macro: PHASE_TIMER_RETRIGGER_EN. When it is defined, a start
// request while busy reloads the timer. When it is undefined, such a start is
// ignored.
module phase_timer #(
    parameter int CNT_W          = 6,
    parameter bit RELOAD_DEFAULT = 1'b0
) (
    input  logic             clk_out,
    input  logic             reset,
    input  logic             tick_en,
    input  logic             start,
    input  logic [CNT_W-1:0] load_val,
    input  logic             mode,
    input  logic             hold,
    input  logic             abort,
    output logic             busy,
    output logic [CNT_W-1:0] count,
    output logic             expired
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_r, state_s;
    logic [CNT_W-1:0] count_r, count_s;
    logic [CNT_W-1:0] dur_r, dur_s;
    logic             mode_r, mode_s;
    logic             expired_r, expired_s;
    logic             busy_r, busy_s;

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk_out) begin
        if (!reset) begin
            state_r   <= ST_IDLE;
            count_r   <= CNT_ZERO;
            dur_r     <= CNT_ZERO;
            mode_r    <= RELOAD_DEFAULT;
            expired_r <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            count_r   <= count_s;
            dur_r     <= dur_s;
            mode_r    <= mode_s;
            expired_r <= expired_s;
            busy_r    <= busy_s;
        end
    end

    // Next-state logic. Priority is abort > start > hold > tick.
    always_comb begin
        state_s   = state_r;
        count_s   = count_r;
        dur_s     = dur_r;
        mode_s    = mode_r;
        expired_s = 1'b0;
        busy_s    = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    dur_s   = load_val;
                    mode_s  = mode;
                    count_s = load_val;
                    if (load_val == CNT_ZERO) begin
                        // A zero duration expires immediately without running.
                        expired_s = 1'b1;
                        state_s   = ST_IDLE;
                    end else begin
                        state_s = ST_RUN;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end

            ST_RUN, ST_HOLD: begin
                if (abort) begin
                    state_s = ST_IDLE;
                    count_s = CNT_ZERO;
`ifdef PHASE_TIMER_RETRIGGER_EN
                end else if (start) begin
                    dur_s  = load_val;
                    mode_s = mode;
                    if (load_val == CNT_ZERO) begin
                        // A zero-length retrigger acts as an abort that still signals expiry.
                        state_s   = ST_IDLE;
                        count_s   = CNT_ZERO;
                        expired_s = 1'b1;
                    end else begin
                        state_s = ST_RUN;
                        count_s = load_val;
                    end
`else
                    // A start while busy falls through and is ignored.
`endif
                end else if (state_r == ST_HOLD) begin
                    // Releasing hold costs one edge; counting resumes on the next tick.
                    if (!hold) begin
                        state_s = ST_RUN;
                    end else begin
                        state_s = ST_HOLD;
                    end
                end else if (hold) begin
                    state_s = ST_HOLD;
                end else if (tick_en) begin
                    if (count_r == CNT_ONE) begin
                        expired_s = 1'b1;
                        if (mode_r) begin
                            // Reload on the same edge, so the period is exactly dur_r ticks.
                            count_s = dur_r;
                            state_s = ST_RUN;
                        end else begin
                            count_s = CNT_ZERO;
                            state_s = ST_IDLE;
                        end
                    end else if (count_r != CNT_ZERO) begin
                        count_s = count_r - CNT_ONE;
                    end else begin
                        // The count is never decremented below zero.
                        count_s = count_r;
                    end
                end else begin
                    count_s = count_r;
                end
            end

            default: begin
                state_s = ST_IDLE;
                count_s = CNT_ZERO;
            end
        endcase

        if (state_s != ST_IDLE) begin
            busy_s = 1'b1;
        end else begin
            busy_s = 1'b0;
        end
    end

    assign busy    = busy_r;
    assign count   = count_r;
    assign expired = expired_r;

endmodule
